rfblackwidow_insn_queue: RTL and testbench
==========================================

Name: rfblackwidow_insn_queue

Overview:
- Fetch-side instruction queue that feeds the instruction decoder.
- Buffers 40-bit instruction words from fetch and presents the head instruction on ir_o.
- Presents the three following words on ir1_o..ir3_o so the decoder can fold CON1/CON2/CON3 constant postfixes into a 128-bit immediate.
- On decoder accept, retires the head together with its postfix chain as one unit.

Parameters:
- IW, 40, instruction word width.
- OPW, 7, opcode field width; the opcode occupies bits [OPW-1:0].
- QDEP, 8, queue depth in words; must be a power of two and at least 4.
- CON1_OP, package CON1, opcode of the first postfix.
- CON2_OP, package CON2, opcode of the second postfix.
- CON3_OP, package CON3, opcode of the third postfix.
- NOP_WORD, package NOP encoding, word driven on any slot with no valid entry.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all queued words (branch redirect).
- fetch_valid_i  in  1  fetch_word_i is valid.
- fetch_word_i  in  IW  instruction word from fetch.
- fetch_ready_o  out  1  queue can accept a word this cycle.
- dec_ready_i  in  1  decoder accepts the presented instruction.
- dec_valid_o  out  1  ir_o..ir3_o hold a complete instruction and postfix chain.
- ir_o  out  IW  head instruction.
- ir1_o  out  IW  word head+1, or NOP_WORD if absent.
- ir2_o  out  IW  word head+2, or NOP_WORD if absent.
- ir3_o  out  IW  word head+3, or NOP_WORD if absent.
- ncon_o  out  2  number of postfix words attached to the head (0..3).
- count_o  out  $clog2(QDEP)+1  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Circular buffer with registered rd_ptr, wr_ptr and count.
  - Pointers wrap modulo QDEP.
  - Storage contents are not reset.
- Reset (rst_ni low, asynchronous): rd_ptr=0, wr_ptr=0, count=0. Resulting outputs: dec_valid_o=0, ncon_o=0, ir_o..ir3_o=NOP_WORD, fetch_ready_o=1, count_o=0.
- Output window:
  - Combinational from storage: slot i (i=0..3) = mem[rd_ptr+i] if count>i, else NOP_WORD.
  - A word pushed in cycle t is visible on the outputs in cycle t+1.
- Postfix chain (orders are strict):
  - c1 = count>=2 and op(slot1)==CON1_OP.
  - c2 = c1 and count>=3 and op(slot2)==CON2_OP.
  - c3 = c2 and count>=4 and op(slot3)==CON3_OP.
  - ncon_o = c1+c2+c3.
  - An out-of-order CON word (for example CON2 in slot1) ends the chain and is later issued as an ordinary head instruction.
  - A CON-opcode word at the head is treated as an ordinary instruction.
- dec_valid_o = count>=1 and (c3 or count >= ncon_o+2).
  - The next word beyond the chain must be present to prove the chain has ended. Otherwise the head is withheld.
- Accept: when dec_valid_o and dec_ready_i, pop p = 1+ncon_o entries; rd_ptr += p.
- Push:
  - fetch_ready_o = (count<QDEP), from the registered count only.
  - When full, no push is accepted even if a pop occurs in the same cycle.
  - When fetch_valid_i and fetch_ready_o, write mem[wr_ptr] and increment wr_ptr.
- Count update: count_next = count + push - pop. Simultaneous push and pop is legal.
- Flush:
  - When flush_i is high, next state is rd_ptr=wr_ptr=0, count=0.
  - Any push or pop in the same cycle is discarded.
  - flush_i overrides all other activity.
- dec_ready_i while dec_valid_o=0 has no effect.
- No overflow or underflow is possible by construction. The bench asserts that count never exceeds QDEP.

Test Plan:
- Reset, then push 3 plain ADDI words A,B,C with dec_ready_i=0 → after the third push: count_o=3, ir_o=A, ir1_o=B, ir2_o=C, ir3_o=NOP_WORD, ncon_o=0, dec_valid_o=1. Then one cycle of dec_ready_i=1 → ir_o=B, count_o=2.
- Push LDO, CON1, CON2, CON3, ADD → dec_valid_o=1 once the CON3 word is queued, with ncon_o=3. Accept → count drops by 4 and ir_o=ADD.
- Push BZ, CON1 only → dec_valid_o=0. Push XORI → dec_valid_o=1, ncon_o=1. Accept → ir_o=XORI.
- Push ADD, CON2, SUB → ncon_o=0, dec_valid_o=1. Accept → ir_o is the CON2 word, issued as its own instruction.
- Fill 8 words with dec_ready_i=0 → fetch_ready_o=0 and a 9th push is ignored. Hold fetch_valid_i high with one accept → fetch_ready_o=1 the next cycle and the 9th word lands in the wrapped slot 0.
- Reset and flush cases:
  - With 5 queued, flush_i=1 together with fetch_valid_i=1 → next cycle count_o=0, dec_valid_o=0, new word dropped.
  - rst_ni low mid-stream → immediate count_o=0, outputs at NOP_WORD.

Source files
------------

// File: rtl/rfblackwidow_insn_queue.sv
// Fetch-side instruction queue: buffers fetch words and presents the head plus
// its CON1/CON2/CON3 postfix window to the decoder, retiring the chain as one unit.

package rfblackwidow_pkg;
  localparam logic [6:0]  CON1 = 7'h71;
  localparam logic [6:0]  CON2 = 7'h72;
  localparam logic [6:0]  CON3 = 7'h73;
  localparam logic [39:0] NOP  = 40'h00_0000_0013;
endpackage

module rfblackwidow_insn_queue #(
  parameter int unsigned    IW       = 40,
  parameter int unsigned    OPW      = 7,
  parameter int unsigned    QDEP     = 8,
  parameter logic [OPW-1:0] CON1_OP  = rfblackwidow_pkg::CON1,
  parameter logic [OPW-1:0] CON2_OP  = rfblackwidow_pkg::CON2,
  parameter logic [OPW-1:0] CON3_OP  = rfblackwidow_pkg::CON3,
  parameter logic [IW-1:0]  NOP_WORD = rfblackwidow_pkg::NOP
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [IW-1:0]            fetch_word_i,
  output logic                     fetch_ready_o,
  input  logic                     dec_ready_i,
  output logic                     dec_valid_o,
  output logic [IW-1:0]            ir_o,
  output logic [IW-1:0]            ir1_o,
  output logic [IW-1:0]            ir2_o,
  output logic [IW-1:0]            ir3_o,
  output logic [1:0]               ncon_o,
  output logic [$clog2(QDEP):0]    count_o
);

  localparam int unsigned PW = $clog2(QDEP);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0] mem_q [QDEP];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [IW-1:0] slot [4];
  logic          c1, c2, c3;
  logic [1:0]    ncon;
  logic          valid;
  logic          push, pop;
  logic [CW-1:0] pop_n;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      slot[i] = NOP_WORD;
      if (count_q > CW'(i)) slot[i] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

  // Chain order is strict; an out-of-place CON word terminates it.
  assign c1 = (count_q >= CW'(2)) && (slot[1][OPW-1:0] == CON1_OP);
  assign c2 = c1 && (count_q >= CW'(3)) && (slot[2][OPW-1:0] == CON2_OP);
  assign c3 = c2 && (count_q >= CW'(4)) && (slot[3][OPW-1:0] == CON3_OP);
  assign ncon = 2'(c1) + 2'(c2) + 2'(c3);

  // Head is withheld until the word after the chain proves the chain is complete.
  assign valid = (count_q != '0) && (c3 || (count_q >= CW'(ncon) + CW'(2)));

  assign fetch_ready_o = (count_q < CW'(QDEP));
  assign push          = fetch_valid_i && fetch_ready_o;
  assign pop           = valid && dec_ready_i;
  assign pop_n         = pop ? CW'(ncon) + CW'(1) : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      count_d  = count_q + CW'(push) - pop_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= fetch_word_i;
  end

  assign dec_valid_o = valid;
  assign ir_o        = slot[0];
  assign ir1_o       = slot[1];
  assign ir2_o       = slot[2];
  assign ir3_o       = slot[3];
  assign ncon_o      = ncon;
  assign count_o     = count_q;

endmodule

// File: tb/tb_rfblackwidow_insn_queue.sv
// Directed bench for rfblackwidow_insn_queue with hand-computed expectations.

module tb_rfblackwidow_insn_queue;

  localparam int unsigned QDEP = 8;
  localparam logic [39:0] NOP  = 40'h00_0000_0013;

  localparam logic [39:0] W_A    = 40'h00_0000_0093;
  localparam logic [39:0] W_B    = 40'h00_0000_0113;
  localparam logic [39:0] W_C    = 40'h00_0000_0193;
  localparam logic [39:0] W_LDO  = 40'h00_0001_2003;
  localparam logic [39:0] W_C1   = 40'h11_1111_1171;
  localparam logic [39:0] W_C2   = 40'h22_2222_2272;
  localparam logic [39:0] W_C3   = 40'h33_3333_3373;
  localparam logic [39:0] W_ADD  = 40'h00_0000_2233;
  localparam logic [39:0] W_SUB  = 40'h00_4000_2233;
  localparam logic [39:0] W_BZ   = 40'h00_0000_0463;
  localparam logic [39:0] W_XORI = 40'h00_0055_4213;
  localparam logic [39:0] W_E    = 40'h00_0077_0293;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, fv, dr;
  logic [39:0] fw;
  logic        fetch_ready, dec_valid;
  logic [39:0] ir, ir1, ir2, ir3;
  logic [1:0]  ncon;
  logic [3:0]  count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [39:0] fill [9];

  rfblackwidow_insn_queue #(.QDEP(QDEP)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .fetch_valid_i (fv),
    .fetch_word_i  (fw),
    .fetch_ready_o (fetch_ready),
    .dec_ready_i   (dr),
    .dec_valid_o   (dec_valid),
    .ir_o          (ir),
    .ir1_o         (ir1),
    .ir2_o         (ir2),
    .ir3_o         (ir3),
    .ncon_o        (ncon),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [39:0] w, input logic r, input logic f);
    fv = v; fw = w; dr = r; flush = f;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (count <= 4'(QDEP)) else begin
        errors++;
        $error("FAIL count_bound: observed %0d expected <= %0d", count, QDEP);
      end
    end
  end

  initial begin
    fv = 1'b0; fw = '0; dr = 1'b0; flush = 1'b0;
    for (int k = 0; k < 9; k++) fill[k] = {33'(k + 100), 7'h13};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_ncon", ncon, 0);
    chk("rst_ir", ir, NOP);
    chk("rst_ir3", ir3, NOP);
    chk("rst_ready", fetch_ready, 1);

    // plain words
    step(1, W_A, 0, 0);
    chk("one_word_valid", dec_valid, 0);
    step(1, W_B, 0, 0);
    step(1, W_C, 0, 0);
    chk("plain_count", count, 3);
    chk("plain_ir", ir, W_A);
    chk("plain_ir1", ir1, W_B);
    chk("plain_ir2", ir2, W_C);
    chk("plain_ir3", ir3, NOP);
    chk("plain_ncon", ncon, 0);
    chk("plain_valid", dec_valid, 1);
    step(0, '0, 1, 0);
    chk("plain_pop_ir", ir, W_B);
    chk("plain_pop_count", count, 2);

    // full CON chain
    step(0, '0, 0, 1);
    chk("flush_count", count, 0);
    step(1, W_LDO, 0, 0);
    step(1, W_C1, 0, 0);
    step(1, W_C2, 0, 0);
    chk("chain2_ncon", ncon, 2);
    chk("chain2_valid", dec_valid, 0);
    step(1, W_C3, 0, 0);
    chk("chain3_ncon", ncon, 3);
    chk("chain3_valid", dec_valid, 1);
    step(1, W_ADD, 0, 0);
    chk("chain3_count", count, 5);
    step(0, '0, 1, 0);
    chk("chain3_pop_count", count, 1);
    chk("chain3_pop_ir", ir, W_ADD);
    chk("chain3_pop_valid", dec_valid, 0);

    // incomplete chain withheld, then simultaneous push/pop
    step(0, '0, 0, 1);
    step(1, W_BZ, 0, 0);
    step(1, W_C1, 0, 0);
    chk("chain1_wait_valid", dec_valid, 0);
    chk("chain1_wait_ncon", ncon, 1);
    step(1, W_XORI, 0, 0);
    chk("chain1_valid", dec_valid, 1);
    chk("chain1_ncon", ncon, 1);
    step(1, W_E, 1, 0);
    chk("chain1_pop_ir", ir, W_XORI);
    chk("chain1_pop_ir1", ir1, W_E);
    chk("pushpop_count", count, 2);

    // out-of-order CON2 issued as its own head
    step(0, '0, 0, 1);
    step(1, W_ADD, 0, 0);
    step(1, W_C2, 0, 0);
    step(1, W_SUB, 0, 0);
    chk("ooo_ncon", ncon, 0);
    chk("ooo_valid", dec_valid, 1);
    step(0, '0, 1, 0);
    chk("ooo_pop_ir", ir, W_C2);
    chk("ooo_pop_ncon", ncon, 0);
    chk("ooo_pop_valid", dec_valid, 1);

    // fill to full and wrap
    step(0, '0, 0, 1);
    for (int k = 0; k < 8; k++) step(1, fill[k], 0, 0);
    chk("full_count", count, 8);
    chk("full_ready", fetch_ready, 0);
    chk("full_ir", ir, fill[0]);
    step(1, fill[8], 0, 0);
    chk("full_drop_count", count, 8);
    step(1, fill[8], 1, 0);
    chk("full_pop_count", count, 7);
    chk("full_pop_ready", fetch_ready, 1);
    chk("full_pop_ir", ir, fill[1]);
    step(1, fill[8], 0, 0);
    chk("refill_count", count, 8);
    chk("refill_ready", fetch_ready, 0);
    repeat (4) step(0, '0, 1, 0);
    chk("wrap_count", count, 4);
    chk("wrap_ir", ir, fill[5]);
    chk("wrap_ir3", ir3, fill[8]);

    // flush overrides push
    step(1, W_A, 0, 0);
    chk("pre_flush_count", count, 5);
    step(1, W_B, 1, 1);
    chk("flush_push_count", count, 0);
    chk("flush_push_valid", dec_valid, 0);
    chk("flush_push_ir", ir, NOP);
    step(0, '0, 0, 0);
    chk("flush_idle_count", count, 0);

    // asynchronous reset mid-stream
    step(1, W_A, 0, 0);
    step(1, W_B, 0, 0);
    chk("pre_rst_count", count, 2);
    fv = 1'b0; dr = 1'b0; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_ir", ir, NOP);
    chk("async_rst_ir1", ir1, NOP);
    chk("async_rst_valid", dec_valid, 0);
    chk("async_rst_ready", fetch_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, W_C, 0, 0);
    chk("post_rst_count", count, 1);
    chk("post_rst_ir", ir, W_C);
    step(0, '0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
